// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station for ALU-class ops: wakes operands from the ALU/LSB
// broadcast buses and dispatches one ready entry per cycle. RS_FWD_DISPATCH_EN lets a
// broadcast that completes an entry's last operand dispatch it at that same edge.
module alu_reservation_station #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [6:0]       issue_opcode,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_name,
  input  logic [31:0]      alu_cdb_value,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_name,
  input  logic [31:0]      lsb_cdb_value,
  output logic             alu_valid,
  output logic [6:0]       alu_opcode,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [31:0]      alu_imm,
  output logic [TAG_W-1:0] alu_name
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic             busy_q    [RS_SIZE];
  logic [6:0]       opcode_q  [RS_SIZE];
  logic [31:0]      pc_q      [RS_SIZE];
  logic [31:0]      imm_q     [RS_SIZE];
  logic [31:0]      vj_q      [RS_SIZE];
  logic [31:0]      vk_q      [RS_SIZE];
  logic             qj_busy_q [RS_SIZE];
  logic             qk_busy_q [RS_SIZE];
  logic [TAG_W-1:0] qj_q      [RS_SIZE];
  logic [TAG_W-1:0] qk_q      [RS_SIZE];
  logic [TAG_W-1:0] dest_q    [RS_SIZE];
  logic [CNT_W-1:0] count_q, count_d;

  // Entry state after this cycle's broadcasts are applied.
  logic [31:0] vj_w      [RS_SIZE];
  logic [31:0] vk_w      [RS_SIZE];
  logic        qj_busy_w [RS_SIZE];
  logic        qk_busy_w [RS_SIZE];
  logic        cand      [RS_SIZE];

  logic             free_found, sel_found, do_issue;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic [31:0]      iss_vj, iss_vk;
  logic             iss_qj_busy, iss_qk_busy;

  always_comb begin
    iss_vj      = issue_vj;
    iss_qj_busy = issue_qj_busy;
    iss_vk      = issue_vk;
    iss_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (alu_cdb_valid && alu_cdb_name == issue_qj) begin
        iss_vj      = alu_cdb_value;
        iss_qj_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_name == issue_qj) begin
        iss_vj      = lsb_cdb_value;
        iss_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (alu_cdb_valid && alu_cdb_name == issue_qk) begin
        iss_vk      = alu_cdb_value;
        iss_qk_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_name == issue_qk) begin
        iss_vk      = lsb_cdb_value;
        iss_qk_busy = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      vj_w[i]      = vj_q[i];
      qj_busy_w[i] = qj_busy_q[i];
      vk_w[i]      = vk_q[i];
      qk_busy_w[i] = qk_busy_q[i];
      if (busy_q[i] && qj_busy_q[i]) begin
        if (alu_cdb_valid && alu_cdb_name == qj_q[i]) begin
          vj_w[i]      = alu_cdb_value;
          qj_busy_w[i] = 1'b0;
        end else if (lsb_cdb_valid && lsb_cdb_name == qj_q[i]) begin
          vj_w[i]      = lsb_cdb_value;
          qj_busy_w[i] = 1'b0;
        end
      end
      if (busy_q[i] && qk_busy_q[i]) begin
        if (alu_cdb_valid && alu_cdb_name == qk_q[i]) begin
          vk_w[i]      = alu_cdb_value;
          qk_busy_w[i] = 1'b0;
        end else if (lsb_cdb_valid && lsb_cdb_name == qk_q[i]) begin
          vk_w[i]      = lsb_cdb_value;
          qk_busy_w[i] = 1'b0;
        end
      end
`ifdef RS_FWD_DISPATCH_EN
      cand[i] = busy_q[i] && !qj_busy_w[i] && !qk_busy_w[i];
`else
      cand[i] = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
`endif
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (cand[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    do_issue = issue_valid && !rs_full && free_found;
    count_d  = count_q + CNT_W'(do_issue) - CNT_W'(sel_found);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        busy_q[i]    <= 1'b0;
        opcode_q[i]  <= '0;
        pc_q[i]      <= '0;
        imm_q[i]     <= '0;
        vj_q[i]      <= '0;
        vk_q[i]      <= '0;
        qj_busy_q[i] <= 1'b0;
        qk_busy_q[i] <= 1'b0;
        qj_q[i]      <= '0;
        qk_q[i]      <= '0;
        dest_q[i]    <= '0;
      end
      count_q    <= '0;
      rs_full    <= 1'b0;
      alu_valid  <= 1'b0;
      alu_opcode <= '0;
      alu_pc     <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_imm    <= '0;
      alu_name   <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int unsigned i = 0; i < RS_SIZE; i++) busy_q[i] <= 1'b0;
        count_q   <= '0;
        rs_full   <= 1'b0;
        alu_valid <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          vj_q[i]      <= vj_w[i];
          vk_q[i]      <= vk_w[i];
          qj_busy_q[i] <= qj_busy_w[i];
          qk_busy_q[i] <= qk_busy_w[i];
        end
        alu_valid <= sel_found;
        if (sel_found) begin
          busy_q[sel_idx] <= 1'b0;
          alu_opcode      <= opcode_q[sel_idx];
          alu_pc          <= pc_q[sel_idx];
          alu_imm         <= imm_q[sel_idx];
          alu_rs1         <= vj_w[sel_idx];
          alu_rs2         <= vk_w[sel_idx];
          alu_name        <= dest_q[sel_idx];
        end
        // The free slot is never the dispatched slot, so these writes never collide.
        if (do_issue) begin
          busy_q[free_idx]    <= 1'b1;
          opcode_q[free_idx]  <= issue_opcode;
          pc_q[free_idx]      <= issue_pc;
          imm_q[free_idx]     <= issue_imm;
          vj_q[free_idx]      <= iss_vj;
          vk_q[free_idx]      <= iss_vk;
          qj_busy_q[free_idx] <= iss_qj_busy;
          qk_busy_q[free_idx] <= iss_qk_busy;
          qj_q[free_idx]      <= issue_qj;
          qk_q[free_idx]      <= issue_qk;
          dest_q[free_idx]    <= issue_dest;
        end
        count_q <= count_d;
        rs_full <= (count_d == CNT_W'(RS_SIZE));
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: stimulus pushes expected dispatches into a
// scoreboard queue, a negedge monitor pops and compares each alu_valid cycle.
module tb_alu_reservation_station;

`ifdef RS_FWD_DISPATCH_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_in, rst_n, rdy_in, clear_in;
  logic        issue_valid;
  logic [6:0]  issue_opcode;
  logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
  logic        issue_qj_busy, issue_qk_busy;
  logic [4:0]  issue_qj, issue_qk, issue_dest;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [4:0]  alu_cdb_name, lsb_cdb_name;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        alu_valid;
  logic [6:0]  alu_opcode;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [4:0]  alu_name;

  alu_reservation_station #(.RS_SIZE(16), .TAG_W(5)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_name(alu_cdb_name), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_name(lsb_cdb_name), .lsb_cdb_value(lsb_cdb_value),
    .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_pc(alu_pc), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_name(alu_name)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] nm);
    sb.push_back('{op: op, pc: pc, imm: imm, rs1: rs1, rs2: rs2, name: nm});
  endtask

  // Each alu_valid seen at a falling edge is a fresh dispatch from the preceding rising edge.
  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && alu_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dispatch: got name %0d, expected no dispatch", alu_name);
      end else begin
        mon_e = sb.pop_front();
        check("disp_rs1", alu_rs1, mon_e.rs1);
        check("disp_rs2", alu_rs2, mon_e.rs2);
        check("disp_name", 32'(alu_name), 32'(mon_e.name));
        check("disp_pc", alu_pc, mon_e.pc);
        check("disp_imm", alu_imm, mon_e.imm);
        check("disp_opcode", 32'(alu_opcode), 32'(mon_e.op));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_issue(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] vj, input logic [31:0] vk, input logic qjb,
                             input logic [4:0] qj, input logic qkb, input logic [4:0] qk,
                             input logic [4:0] dest);
    issue_valid   = 1'b1;
    issue_opcode  = op;
    issue_pc      = pc;
    issue_imm     = imm;
    issue_vj      = vj;
    issue_vk      = vk;
    issue_qj_busy = qjb;
    issue_qj      = qj;
    issue_qk_busy = qkb;
    issue_qk      = qk;
    issue_dest    = dest;
  endtask

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    issue_valid = 1'b0; issue_opcode = '0; issue_pc = '0; issue_imm = '0;
    issue_vj = '0; issue_vk = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_dest = '0;
    alu_cdb_valid = 1'b0; alu_cdb_name = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_name = '0; lsb_cdb_value = '0;

    tick();
    tick();
    check("reset_alu_valid", 32'(alu_valid), 32'd0);
    check("reset_rs_full", 32'(rs_full), 32'd0);
    check("reset_alu_rs1", alu_rs1, 32'd0);
    check("reset_alu_name", 32'(alu_name), 32'd0);
    check("reset_alu_pc", alu_pc, 32'd0);
    rst_n = 1'b1;

    // Both operands ready: dispatch one edge after issue.
    drive_issue(7'h33, 32'h1000, 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    push_exp(7'h33, 32'h1000, 32'h0, 32'd5, 32'd7, 5'd3);
    tick();
    issue_valid = 1'b0;
    check("add_not_same_edge", 32'(alu_valid), 32'd0);
    tick();
    check("add_valid", 32'(alu_valid), 32'd1);
    check("add_rs1", alu_rs1, 32'd5);
    check("add_rs2", alu_rs2, 32'd7);
    check("add_name", 32'(alu_name), 32'd3);
    tick();
    check("add_idle", 32'(alu_valid), 32'd0);

    // Pending qj woken by ALU broadcast two cycles after issue.
    drive_issue(7'h13, 32'h1004, 32'h10, 32'h0, 32'd2, 1'b1, 5'd9, 1'b0, 5'd0, 5'd4);
    push_exp(7'h13, 32'h1004, 32'h10, 32'h100, 32'd2, 5'd4);
    tick();
    issue_valid = 1'b0;
    tick();
    check("wake_waiting", 32'(alu_valid), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_name = 5'd9; alu_cdb_value = 32'h100;
    tick();
    alu_cdb_valid = 1'b0;
    check("wake_edge0", 32'(alu_valid), 32'(FWD));
    tick();
    check("wake_edge1", 32'(alu_valid), 32'(!FWD));
    tick();
    check("wake_idle", 32'(alu_valid), 32'd0);

    // Issue-time bypass from the LSB bus.
    drive_issue(7'h33, 32'h1008, 32'h0, 32'h1111, 32'd9, 1'b1, 5'd4, 1'b0, 5'd0, 5'd6);
    lsb_cdb_valid = 1'b1; lsb_cdb_name = 5'd4; lsb_cdb_value = 32'hDEAD;
    push_exp(7'h33, 32'h1008, 32'h0, 32'hDEAD, 32'd9, 5'd6);
    tick();
    issue_valid = 1'b0; lsb_cdb_valid = 1'b0;
    check("bypass_not_same_edge", 32'(alu_valid), 32'd0);
    tick();
    check("bypass_valid", 32'(alu_valid), 32'd1);
    check("bypass_rs1", alu_rs1, 32'hDEAD);
    tick();

    // Fill all 16 entries with waiting ops; entries 0 and 5 wait on tag 20.
    for (int i = 0; i < 16; i++) begin
      drive_issue(7'h33, 32'h2000 + 32'(4 * i), 32'(i), 32'h0, 32'(3 * i), 1'b1,
                  (i == 0 || i == 5) ? 5'd20 : 5'd10, 1'b0, 5'd0, 5'(i));
      tick();
      if (i == 14) check("not_full_at_15", 32'(rs_full), 32'd0);
    end
    check("full_at_16", 32'(rs_full), 32'd1);
    drive_issue(7'h33, 32'h3FFC, 32'h0, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd31);
    tick();
    issue_valid = 1'b0;
    check("full_after_drop", 32'(rs_full), 32'd1);
    push_exp(7'h33, 32'h2000, 32'd0, 32'h55, 32'd0, 5'd0);
    push_exp(7'h33, 32'h2014, 32'd5, 32'h55, 32'd15, 5'd5);
    alu_cdb_valid = 1'b1; alu_cdb_name = 5'd20; alu_cdb_value = 32'h55;
    tick();
    alu_cdb_valid = 1'b0;
    check("fill_edge0_valid", 32'(alu_valid), 32'(FWD));
    tick();
    check("fill_edge1_valid", 32'(alu_valid), 32'd1);
    check("fill_edge1_name", 32'(alu_name), FWD ? 32'd5 : 32'd0);
    check("fill_full_drops", 32'(rs_full), 32'd0);
    tick();
    check("fill_edge2_valid", 32'(alu_valid), 32'(!FWD));
    tick();
    check("fill_edge3_idle", 32'(alu_valid), 32'd0);

    // Flush the 14 remaining waiters; a later broadcast must wake nothing.
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("clear_full", 32'(rs_full), 32'd0);
    check("clear_valid", 32'(alu_valid), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_name = 5'd10; alu_cdb_value = 32'h77;
    tick();
    alu_cdb_valid = 1'b0;
    tick();
    tick();
    check("clear_no_dispatch", 32'(alu_valid), 32'd0);

    // Global stall holds a ready entry.
    drive_issue(7'h33, 32'h3000, 32'h0, 32'hA, 32'hB, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    push_exp(7'h33, 32'h3000, 32'h0, 32'hA, 32'hB, 5'd7);
    tick();
    issue_valid = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 32'(alu_valid), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check("stall_release_valid", 32'(alu_valid), 32'd1);
    check("stall_release_name", 32'(alu_name), 32'd7);
    tick();

    // Asynchronous reset mid-stream with a waiter still resident.
    drive_issue(7'h33, 32'h4000, 32'h0, 32'h0, 32'd1, 1'b1, 5'd12, 1'b0, 5'd0, 5'd8);
    tick();
    drive_issue(7'h33, 32'h4004, 32'h0, 32'h21, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
    push_exp(7'h33, 32'h4004, 32'h0, 32'h21, 32'h22, 5'd9);
    tick();
    issue_valid = 1'b0;
    tick();
    check("pre_reset_valid", 32'(alu_valid), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(alu_valid), 32'd0);
    check("async_reset_rs1", alu_rs1, 32'd0);
    check("async_reset_rs2", alu_rs2, 32'd0);
    check("async_reset_name", 32'(alu_name), 32'd0);
    check("async_reset_opcode", 32'(alu_opcode), 32'd0);
    check("async_reset_full", 32'(rs_full), 32'd0);
    #2;
    rst_n = 1'b1;
    alu_cdb_valid = 1'b1; alu_cdb_name = 5'd12; alu_cdb_value = 32'h99;
    tick();
    alu_cdb_valid = 1'b0;
    tick();
    tick();
    check("reset_cleared_entries", 32'(alu_valid), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Tomasulo reservation station that holds decoded ALU-class instructions until both operands are ready, then issues exactly one per cycle into the combinational ALU.
- Snoops the ALU and LSB broadcast buses to wake up waiting operands.
- Sits between the decoder/dispatcher and the ALU.
- Flushed on branch mispredict.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥2)
- TAG_W, 5, ROB tag width (matches ALU finish name)

Ports:
- clk_in  input  1  clock
- rst_n  input  1  reset, active-low
- rdy_in  input  1  global ready; low = hold all state
- clear_in  input  1  mispredict flush
- issue_valid  input  1  decoder presents instruction
- issue_opcode  input  7  ALU op type
- issue_pc  input  32  instruction pc
- issue_imm  input  32  immediate
- issue_vj, issue_vk  input  32  operand values
- issue_qj_busy, issue_qk_busy  input  1  operand still pending
- issue_qj, issue_qk  input  TAG_W  pending producer tags
- issue_dest  input  TAG_W  destination ROB tag
- rs_full  output  1  no free entry
- alu_cdb_valid  input  1  ALU broadcast
- alu_cdb_name  input  TAG_W  ALU broadcast tag
- alu_cdb_value  input  32  ALU broadcast value
- lsb_cdb_valid  input  1  LSB broadcast
- lsb_cdb_name  input  TAG_W  LSB broadcast tag
- lsb_cdb_value  input  32  LSB broadcast value
- alu_valid  output  1  ALU inputs valid this cycle
- alu_opcode  output  7  op to ALU
- alu_pc  output  32  pc to ALU
- alu_rs1, alu_rs2  output  32  operands to ALU
- alu_imm  output  32  imm to ALU
- alu_name  output  TAG_W  tag to ALU calc name

Behaviour:
- Reset (rst_n=0, asynchronous): all entries not busy, count=0, rs_full=0, alu_valid=0, all alu_* data outputs 0.
- rdy_in=0: no state changes; outputs hold.
- Entry fields: busy, opcode, pc, imm, vj, vk, qj_busy, qj, qk_busy, qk, dest.
- Issue (rdy_in=1, clear_in=0, issue_valid=1, rs_full=0): write the lowest-index free entry at the clock edge.
  - Issue-time bypass: if issue_qj_busy and a valid broadcast in the same cycle matches issue_qj, store that value and mark qj ready. Same for qk.
  - ALU bus has priority over LSB if both match (cannot occur legally).
  - issue_valid while rs_full=1: dropped; the decoder must stall.
- Wake-up, every edge: for each busy entry with qj_busy and a matching broadcast tag, capture the value and clear qj_busy. Same for qk.
- Select:
  - Combinational.
  - Candidate = busy and !qj_busy and !qk_busy from current registered state.
  - Choose the lowest index.
- Dispatch, registered:
  - At the edge, drive alu_valid=1 and alu_* from the chosen entry; clear its busy.
  - No candidate: alu_valid=0 and data outputs hold.
  - Latency: issue with ready operands at edge N → alu_valid at edge N+1 earliest.
  - Broadcast wake-up at edge N → dispatch at edge N+1.
- Count and full:
  - count += issued − dispatched.
  - rs_full is registered and equals (next count == RS_SIZE).
  - Simultaneous issue and dispatch keeps count unchanged.
  - When full with one dispatching, rs_full is still 1 in the same cycle (conservative).
- clear_in=1 (rdy_in=1):
  - At the edge, all busy cleared, count=0, rs_full=0, alu_valid=0.
  - Issue and dispatch in that cycle are discarded.
  - clear_in takes priority over everything except reset.
- A tag that matches both operands of one entry updates both.
- Reset asserted mid-operation: immediate return to reset state.

Optional Feature:
- Macro: RS_FWD_DISPATCH_EN.
- Defined:
  - An entry becomes a candidate in the same cycle a broadcast completes its last pending operand.
  - Dispatch uses the broadcast value for that operand.
  - Wake-up-to-alu_valid latency drops to 0 extra cycles: the broadcast at cycle N is seen combinationally, and alu_valid is registered at edge N.
  - Priority: still lowest index among all candidates, including the newly woken.
- Undefined: candidates come from registered state only, per Behaviour.

Test Plan:
- Issue ADD (opcode ADD_type), vj=5, vk=7, both ready, dest=3 → next edge alu_valid=1, alu_rs1=5, alu_rs2=7, alu_name=3; count back to 0.
- Issue with qj_busy=1, qj=9, then alu_cdb_valid=1, name=9, value=0x100 two cycles later → alu_rs1=0x100 one edge after the broadcast; 0 edges after with RS_FWD_DISPATCH_EN.
- Issue with qj=4 in the same cycle as lsb_cdb name=4, value=0xDEAD → entry stored ready; dispatch next edge with alu_rs1=0xDEAD.
- Fill 16 waiting entries → rs_full=1; 17th issue_valid ignored. Wake entries 0 and 5 with one broadcast → dispatch entry 0, then entry 5 on consecutive edges; rs_full drops.
- 10 busy entries, assert clear_in → next edge count=0, rs_full=0, alu_valid=0; later broadcasts cause no dispatch.
- rdy_in=0 for 3 cycles with a ready entry → no alu_valid. rdy_in=1 → dispatch next edge.
- Async reset pulse mid-stream → all outputs 0 immediately.
